// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, I2S frame length, offset-binary midscale.
package audio_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Offset-binary to two's complement: flipping the MSB moves midscale to zero.
  function automatic sample_t to_twos(input sample_t s);
    return s ^ MIDSCALE;
  endfunction
endpackage

// File: rtl/i2s_tx_if.sv
// Sample stream handshake into the I2S transmitter (producer = master).
interface i2s_tx_if;
  import audio_pkg::*;
  sample_t sample_in;
  logic    sample_valid;
  logic    sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit clock generator: CLK_DIV clk cycles per BCLK half-period, with a strobe
// that is high in the cycle whose closing edge drives BCLK from 1 to 0.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_active_high,
  output logic bclk,
  output logic fall_evt
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = (div_cnt == LAST);
  assign fall_evt = wrap && bclk;

  // Divider counts 0..CLK_DIV-1 and toggles BCLK on wrap.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips) mono transmitter: one-entry holding register, both channels
// carry the same two's-complement word, MSB one BCLK after the LRCLK edge.
// Build option: I2S_TX_UNDERRUN_HOLD_EN repeats the last word on underrun
// instead of sending silence.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_active_high,
  i2s_tx_if.slave    s,
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_sdata,
  output logic       underrun
);
  localparam int BW = $clog2(FRAME_BITS);

  logic          fall_evt;
  logic [BW-1:0] bit_cnt, k_next;
  logic [3:0]    sel;
  logic          accept, load, full, full_next;
  sample_t       hold, cur, cur_next;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .bclk            (i2s_bclk),
    .fall_evt        (fall_evt)
  );

  // Next-state for the frame word and the holding flag; the load happens on
  // the fall entering slot 1 so slot 0 can still send the previous LSB.
  always_comb begin
    k_next    = bit_cnt + 1'b1;
    accept    = s.sample_valid && s.sample_ready;
    load      = fall_evt && (k_next == BW'(1));
    cur_next  = cur;
    full_next = full;
    if (load) begin
      if (full) begin
        cur_next  = hold;
        full_next = 1'b0;
      end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        cur_next = cur;
`else
        cur_next = '0;
`endif
      end
    end
    if (accept) full_next = 1'b1;
    // slot k%16 == 0 carries bit 0, otherwise bit 16 - k%16
    sel = 4'd0 - k_next[3:0];
  end

  // Handshake register, bit slot counter and serial output registers.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      hold           <= '0;
      full           <= 1'b0;
      cur            <= '0;
      bit_cnt        <= BW'(FRAME_BITS - 1);
      i2s_lrclk      <= 1'b1;
      i2s_sdata      <= 1'b0;
      underrun       <= 1'b0;
      s.sample_ready <= 1'b0;
    end else begin
      underrun       <= 1'b0;
      full           <= full_next;
      s.sample_ready <= !full_next;
      if (accept) hold <= to_twos(s.sample_in);
      if (fall_evt) begin
        bit_cnt   <= k_next;
        i2s_lrclk <= k_next[BW-1];
        i2s_sdata <= cur_next[sel];
        cur       <= cur_next;
        if (load && !full) underrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame-level reference model driven by the
// clk edge count since reset, per-cycle output compare, plus literal checks.
module tb_i2s_tx;
  localparam int CLK_DIV = 2;
  localparam int FRAME   = 64 * CLK_DIV;

  logic clk = 0;
  logic rst;
  logic bclk, lrclk, sdata, ur;
  i2s_tx_if bus();

  i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_active_high(rst), .s(bus),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata), .underrun(ur)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          n = 0;        // clk edges since reset release
  int          mk = 31;      // current bit slot
  logic        mfull = 0, mready = 0, mur = 0;
  logic [15:0] mhold = 0, mcur = 0;
  logic        e_bclk = 0, e_lr = 1, e_sd = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      n = 0; mk = 31; mfull = 0; mready = 0; mur = 0; mhold = 0; mcur = 0;
      e_bclk = 0; e_lr = 1; e_sd = 0;
    end else begin
      automatic logic acc = bus.sample_valid && mready;
      n++;
      mur = 0;
      if (n % (2 * CLK_DIV) == 0) begin
        automatic int m = n / (2 * CLK_DIV);
        mk = (m - 1) % 32;
        if (mk == 1) begin
          if (mfull) begin
            mcur = mhold; mfull = 0;
          end else begin
            mur = 1;
`ifndef I2S_TX_UNDERRUN_HOLD_EN
            mcur = 16'h0000;
`endif
          end
        end
        e_lr = (mk >= 16);
        e_sd = (mk % 16 == 0) ? mcur[0] : mcur[16 - mk % 16];
      end
      e_bclk = ((n / CLK_DIV) % 2) == 1;
      if (acc) begin mhold = bus.sample_in ^ 16'h8000; mfull = 1; end
      mready = !mfull;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("bclk", bclk, e_bclk);
    chk("lrclk", lrclk, e_lr);
    chk("sdata", sdata, e_sd);
    chk("underrun", ur, mur);
    chk("ready", bus.sample_ready, mready);
  end

  // ---------------- receiver: deserialize on BCLK rise ----------------
  logic [15:0] left_q[$], right_q[$];
  initial begin
    automatic int rcnt = 0;
    automatic logic [15:0] lw = 0, rw = 0;
    forever begin
      @(posedge bclk or posedge rst);
      if (rst) rcnt = 0;
      else begin
        rcnt++;
        if (rcnt >= 2) begin
          automatic int k = (rcnt - 2) % 32;
          if (k >= 1 && k <= 16) lw = {lw[14:0], sdata};
          if (k == 16) left_q.push_back(lw);
          if (k >= 17 || (k == 0 && rcnt >= 34)) rw = {rw[14:0], sdata};
          if (k == 0 && rcnt >= 34) right_q.push_back(rw);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [15:0] d);
    automatic bit done = 0;
    @(negedge clk);
    bus.sample_in = d; bus.sample_valid = 1;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      if (bus.sample_ready) begin @(posedge clk); done = 1; break; end
      @(negedge clk);
    end
    if (!done) chk("push_timeout", 0, 1);
    @(negedge clk);
    bus.sample_valid = 0;
  endtask

  task automatic wait_slot(input int k);
    automatic bit done = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (n > 0 && mk == k) begin done = 1; break; end
    end
    if (!done) chk("slot_timeout", 0, 1);
  endtask

  task automatic wait_lr(input logic v, output int t);
    automatic bit done = 0;
    t = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (lrclk === v) begin done = 1; t = i + 1; break; end
    end
    if (!done) chk("lrclk_timeout", 0, 1);
  endtask

  initial begin
    automatic int cnt = 0, t = 0, t_hi = 0, t_lo = 0, nur = 0;
    automatic logic [15:0] uw;
    rst = 1;
    bus.sample_in = 0; bus.sample_valid = 0;
    repeat (5) @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 1);
    chk("rst_sdata", sdata, 0);
    chk("rst_underrun", ur, 0);
    chk("rst_ready", bus.sample_ready, 0);
    #2 rst = 0;
    // first BCLK rise after CLK_DIV edges; ready one edge after release
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) chk("ready_after_rst", bus.sample_ready, 1);
      if (bclk) break;
    end
    chk("first_rise", cnt, CLK_DIV);

    // single sample, back-pressure, then underrun
    push(16'hC000);
    push(16'h1234);
    push(16'h5678);
    push(16'hFFFF);
    repeat (3 * FRAME) @(negedge clk);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    uw = 16'h7FFF;
`else
    uw = 16'h0000;
`endif
    if (left_q.size() >= 5 && right_q.size() >= 5) begin
      chk("L0", left_q[0], 16'h4000); chk("R0", right_q[0], 16'h4000);
      chk("L1", left_q[1], 16'h9234); chk("R1", right_q[1], 16'h9234);
      chk("L2", left_q[2], 16'hD678); chk("R2", right_q[2], 16'hD678);
      chk("L3", left_q[3], 16'h7FFF); chk("R3", right_q[3], 16'h7FFF);
      chk("L4", left_q[4], uw);       chk("R4", right_q[4], uw);
    end else chk("frame_count", left_q.size(), 5);

    // randomized traffic with random gaps
    for (int i = 0; i < 30; i++) begin
      automatic logic [15:0] d = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      push(d);
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end

    // continuous midscale; measure LRCLK half periods
    fork
      begin for (int i = 0; i < 6; i++) push(16'h8000); end
      begin
        repeat (2 * FRAME) @(negedge clk);
        wait_lr(1'b0, t);
        wait_lr(1'b1, t_lo);
        wait_lr(1'b0, t_hi);
      end
    join
    chk("lrclk_low", t_lo, FRAME / 2);
    chk("lrclk_high", t_hi, FRAME / 2);

    // reset mid-frame with a sample held
    wait_slot(2);
    push(16'($urandom));
    wait_slot(7);
    chk("held_before_rst", mfull, 1);
    #2 rst = 1;
    #1;
    chk("mid_bclk", bclk, 0);
    chk("mid_lrclk", lrclk, 1);
    chk("mid_sdata", sdata, 0);
    chk("mid_underrun", ur, 0);
    chk("mid_ready", bus.sample_ready, 0);
    repeat (3) @(negedge clk);
    #2 rst = 0;
    for (int i = 0; i < 6 * CLK_DIV; i++) begin
      @(negedge clk);
      if (ur) nur++;
    end
    chk("underrun_after_rst", nur, 1);
    repeat (FRAME) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
